// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared helpers for n-bit Johnson (twisted-ring) counter codes. They are used
// by the phase decoder RTL and by the existing counter's test bench.
//   johnson_pw(width)             -> phase index width, $clog2(2*width)
//   johnson_is_legal(code, width) -> 1 if code is one of the 2*width ring states
//   johnson_to_phase(code, width) -> phase index 0..2*width-1 of a legal code
// Codes are passed zero-extended to JOHNSON_MAX_W bits. The real width is a
// separate argument, so a single function serves every counter size.
// Optional feature macro (used by johnson_phase_decoder): JOHNSON_PHASE_GRAY_EN.
// -----------------------------------------------------------------------------
package johnson_pkg;

  localparam int JOHNSON_MAX_W       = 32;
  localparam int JOHNSON_PHASE_MAX_W = 8;

  typedef logic [JOHNSON_MAX_W-1:0]       johnson_code_t;
  typedef logic [JOHNSON_PHASE_MAX_W-1:0] johnson_phase_t;

  // Phase index width for a width-bit Johnson register (2*width phases).
  function automatic int johnson_pw(input int width);
    if (width < 1) begin
      return 1;
    end else begin
      return $clog2(2 * width);
    end
  endfunction

  // The MSB picks which end the run of ones must be anchored to:
  //   MSB=1 -> ones contiguous from the MSB (no 1 directly below a 0)
  //   MSB=0 -> ones contiguous from the LSB (no 0 directly below a 1)
  // All-zero passes the MSB=0 rule. Bits at or above width must be zero.
  function automatic logic johnson_is_legal(input johnson_code_t code, input int width);
    logic legal;
    logic msb;
    legal = 1'b1;
    msb   = code[width-1];
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      if (i >= width) begin
        legal = legal & ~code[i];
      end else if (i < width - 1) begin
        if (msb) begin
          legal = legal & ~(code[i] & ~code[i+1]);
        end else begin
          legal = legal & ~(code[i+1] & ~code[i]);
        end
      end else begin
        legal = legal;
      end
    end
    return legal;
  endfunction

  // The fill half (MSB=1) maps to popcount 1..width. The drain half (MSB=0,
  // nonzero) maps to 2*width - popcount. All-zero maps to phase 0.
  function automatic johnson_phase_t johnson_to_phase(input johnson_code_t code, input int width);
    int ones;
    ones = 0;
    for (int i = 0; i < JOHNSON_MAX_W; i++) begin
      if ((i < width) && code[i]) begin
        ones = ones + 1;
      end else begin
        ones = ones;
      end
    end
    if (code[width-1]) begin
      return johnson_phase_t'(ones);
    end else if (ones == 0) begin
      return '0;
    end else begin
      return johnson_phase_t'(2 * width - ones);
    end
  endfunction

endpackage

// File: rtl/johnson_decode_comb.sv
// -----------------------------------------------------------------------------
// johnson_decode_comb
// Purely combinational decode of one n-bit Johnson code.
// Ports:
//   code   [n-1:0]   raw Johnson code, bit n-1 = MSB
//   legal            code is a valid ring state
//   phase  [PW-1:0]  phase index 0..2n-1 (not meaningful when legal=0)
//   onehot [2n-1:0]  one-hot of phase, all zero when legal=0
// -----------------------------------------------------------------------------
module johnson_decode_comb
  import johnson_pkg::*;
#(
  parameter int n = 4,
  localparam int PW = johnson_pw(n)
) (
  input  logic [n-1:0]   code,
  output logic           legal,
  output logic [PW-1:0]  phase,
  output logic [2*n-1:0] onehot
);

  johnson_code_t  code_ext;
  johnson_phase_t phase_full;

  // Widen the code for the shared helpers, then derive legality, index and one-hot.
  always_comb begin
    code_ext          = '0;
    code_ext[n-1:0]   = code;
    legal             = johnson_is_legal(code_ext, n);
    phase_full        = johnson_to_phase(code_ext, n);
    phase             = phase_full[PW-1:0];
    if (legal) begin
      onehot = {{(2*n-1){1'b0}}, 1'b1} << phase_full;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// -----------------------------------------------------------------------------
// johnson_phase_decoder
// Registers a Johnson counter state and decodes it to a phase index and a
// one-hot phase vector. It also flags illegal codes and phase skips, and it
// counts full revolutions (wraps from 2n-1 to 0). Latency is 2 clocks:
// stage 1 samples the input and stage 2 registers the decode.
// Ports:
//   clk           system clock, rising edge
//   clear         synchronous active-high reset, highest priority
//   en            sample enable; when low, stage 1 marks its slot empty
//   johnson_in    [n-1:0] Johnson code from the counter
//   phase         [PW-1:0] decoded phase index
//   phase_onehot  [2n-1:0] one-hot phase, zero when valid=0
//   valid         outputs reflect a legal sample
//   illegal       sticky, set when an illegal code is sampled
//   step_err      sticky, set when a legal phase is neither prev nor prev+1
//   rev_tick      one-cycle pulse on each 2n-1 -> 0 wrap
//   rev_count     [REV_W-1:0] wrap count modulo 2^REV_W
//   phase_gray    [PW-1:0] Gray code of phase (only with JOHNSON_PHASE_GRAY_EN)
// Optional feature macro: JOHNSON_PHASE_GRAY_EN
// -----------------------------------------------------------------------------
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int n     = 4,
  parameter int REV_W = 8,
  localparam int PW   = johnson_pw(n)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [n-1:0]     johnson_in,
  output logic [PW-1:0]    phase,
  output logic [2*n-1:0]   phase_onehot,
  output logic             valid,
  output logic             illegal,
  output logic             step_err,
  output logic             rev_tick,
`ifdef JOHNSON_PHASE_GRAY_EN
  output logic [PW-1:0]    phase_gray,
`endif
  output logic [REV_W-1:0] rev_count
);

  typedef logic [PW-1:0]    phase_t;
  typedef logic [REV_W-1:0] rev_t;

  localparam phase_t PHASE_LAST = phase_t'(2 * n - 1);

  // Stage 1
  logic [n-1:0]   s1_code_r;
  logic           s1_v_r;

  // Decode of the stage 1 code
  logic           dec_legal_s;
  phase_t         dec_phase_s;
  logic [2*n-1:0] dec_onehot_s;

  // Stage 2 and tracker state
  phase_t         phase_r;
  logic [2*n-1:0] onehot_r;
  logic           valid_r;
  logic           illegal_r;
  logic           step_err_r;
  logic           rev_tick_r;
  rev_t           rev_count_r;
  phase_t         prev_r;
  logic           have_prev_r;

  // Step checker terms
  phase_t         prev_next_s;
  logic           in_seq_s;
  logic           wrap_s;

  // Stage 1: sample the raw code on en. An empty slot leaves stage 2 holding.
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_code_r <= '0;
      s1_v_r    <= 1'b0;
    end else if (en) begin
      s1_code_r <= johnson_in;
      s1_v_r    <= 1'b1;
    end else begin
      s1_v_r    <= 1'b0;
    end
  end

  johnson_decode_comb #(
    .n (n)
  ) u_decode (
    .code   (s1_code_r),
    .legal  (dec_legal_s),
    .phase  (dec_phase_s),
    .onehot (dec_onehot_s)
  );

  // Continuity and wrap detection against the last legal phase.
  // The explicit modulo handles n values where 2n is not a power of two.
  always_comb begin
    prev_next_s = '0;
    if (prev_r == PHASE_LAST) begin
      prev_next_s = '0;
    end else begin
      prev_next_s = prev_r + phase_t'(1);
    end
    in_seq_s = (dec_phase_s == prev_r) || (dec_phase_s == prev_next_s);
    wrap_s   = have_prev_r && (prev_r == PHASE_LAST) && (dec_phase_s == phase_t'(0));
  end

  // Stage 2: decode, sticky flags, tracker and revolution counter.
  // An illegal sample empties the tracker so the next legal one re-seeds cleanly.
  always_ff @(posedge clk) begin
    if (clear) begin
      phase_r     <= '0;
      onehot_r    <= '0;
      valid_r     <= 1'b0;
      illegal_r   <= 1'b0;
      step_err_r  <= 1'b0;
      rev_tick_r  <= 1'b0;
      rev_count_r <= '0;
      prev_r      <= '0;
      have_prev_r <= 1'b0;
    end else if (s1_v_r && dec_legal_s) begin
      phase_r     <= dec_phase_s;
      onehot_r    <= dec_onehot_s;
      valid_r     <= 1'b1;
      if (have_prev_r && !in_seq_s) begin
        step_err_r <= 1'b1;
      end
      rev_tick_r  <= wrap_s;
      if (wrap_s) begin
        rev_count_r <= rev_count_r + rev_t'(1);
      end
      prev_r      <= dec_phase_s;
      have_prev_r <= 1'b1;
    end else if (s1_v_r) begin
      illegal_r   <= 1'b1;
      valid_r     <= 1'b0;
      onehot_r    <= '0;
      rev_tick_r  <= 1'b0;
      have_prev_r <= 1'b0;
    end else begin
      rev_tick_r  <= 1'b0;
    end
  end

`ifdef JOHNSON_PHASE_GRAY_EN
  phase_t gray_r;

  // Gray view of the phase, updated only on legal samples like phase itself.
  always_ff @(posedge clk) begin
    if (clear) begin
      gray_r <= '0;
    end else if (s1_v_r && dec_legal_s) begin
      gray_r <= dec_phase_s ^ (dec_phase_s >> 1);
    end else begin
      gray_r <= gray_r;
    end
  end

  assign phase_gray = gray_r;
`endif

  assign phase        = phase_r;
  assign phase_onehot = onehot_r;
  assign valid        = valid_r;
  assign illegal      = illegal_r;
  assign step_err     = step_err_r;
  assign rev_tick     = rev_tick_r;
  assign rev_count    = rev_count_r;

endmodule
